// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the ADC conversion sequencer
package adc_pkg;

  localparam int MATRIX_BITS_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2,
    DELIVER = 2'd3
  } seq_state_e;

  // Averaging codes understood by the SAR core (number of averaged samples).
  typedef enum logic [2:0] {
    AVG_1  = 3'b000,
    AVG_3  = 3'b001,
    AVG_7  = 3'b010,
    AVG_15 = 3'b011,
    AVG_31 = 3'b100
  } avg_code_e;

endpackage

// File: rtl/adc_next_channel.sv
// rtl/adc_next_channel.sv - priority search for the next enabled mux channel
module adc_next_channel #(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]  mask_i,
  input  logic [CH_BITS-1:0] cur_i,
  output logic [CH_BITS-1:0] next_o,
  output logic               wrap_o,
  output logic [CH_BITS-1:0] first_o
);

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    next_o  = '0;
    wrap_o  = 1'b1;
    first_o = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        first_o = CH_BITS'(i);
        if (CH_BITS'(i) > cur_i) begin
          next_o = CH_BITS'(i);
          wrap_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/adc_conv_sequencer.sv
// rtl/adc_conv_sequencer.sv - multi-channel scan controller in front of the SAR ADC core
// Optional conversion watchdog enabled by defining ADC_SEQ_TIMEOUT_EN.
module adc_conv_sequencer
  import adc_pkg::*;
#(
  parameter int MATRIX_BITS    = MATRIX_BITS_DEFAULT,
  parameter int NUM_CH         = 4,
  parameter int CH_BITS        = $clog2(NUM_CH),
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_in,
  input  logic                   stop_in,
  input  logic                   continuous_in,
  input  logic [NUM_CH-1:0]      channel_mask_in,
  input  logic [2:0]             avg_control_in,
  output logic                   busy_out,
  output logic                   scan_done_strobe_out,
  output logic [CH_BITS-1:0]     mux_sel_out,
  output logic                   core_rst_n_out,
  output logic [2:0]             core_avg_control_out,
  input  logic                   core_conv_finished_in,
  input  logic [MATRIX_BITS-1:0] core_result_in,
  output logic                   result_valid_out,
  input  logic                   result_ready_in,
  output logic [MATRIX_BITS-1:0] result_data_out,
  output logic [CH_BITS-1:0]     result_channel_out,
  output logic                   error_out
);

  seq_state_e             state_q, state_d;
  logic [NUM_CH-1:0]      mask_q, mask_d;
  logic                   cont_q, cont_d;
  logic [2:0]             avg_q, avg_d;
  logic [CH_BITS-1:0]     mux_q, mux_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   valid_q, valid_d;
  logic [MATRIX_BITS-1:0] data_q, data_d;
  logic [CH_BITS-1:0]     ch_q, ch_d;
  logic                   done_q, done_d;
  logic                   stop_q, stop_d;
  logic                   advance;

  logic [NUM_CH-1:0]      search_mask;
  logic [CH_BITS-1:0]     next_ch, first_ch;
  logic                   wrap;

`ifdef ADC_SEQ_TIMEOUT_EN
  logic                   err_q, err_d;
  logic [15:0]            wd_q, wd_d;
`else
  logic                   timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES == 0);
`endif

  // In IDLE the lowest channel must come from the mask being offered, not the stale latch.
  assign search_mask = (state_q == IDLE) ? channel_mask_in : mask_q;

  adc_next_channel #(
    .NUM_CH (NUM_CH),
    .CH_BITS(CH_BITS)
  ) u_next_channel (
    .mask_i (search_mask),
    .cur_i  (mux_q),
    .next_o (next_ch),
    .wrap_o (wrap),
    .first_o(first_ch)
  );

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    cont_d       = cont_q;
    avg_d        = avg_q;
    mux_d        = mux_q;
    cnt_d        = cnt_q;
    core_rst_n_d = core_rst_n_q;
    valid_d      = valid_q;
    data_d       = data_q;
    ch_d         = ch_q;
    done_d       = 1'b0;
    stop_d       = stop_q | ((state_q != IDLE) && stop_in);
    advance      = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
    err_d        = err_q;
    wd_d         = wd_q;
`endif
    case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start_in && (|channel_mask_in)) begin
          mask_d  = channel_mask_in;
          cont_d  = continuous_in;
          avg_d   = avg_control_in;
          mux_d   = first_ch;
          cnt_d   = 8'(SETTLE_CYCLES);
          state_d = SETTLE;
`ifdef ADC_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          core_rst_n_d = 1'b1;
          state_d      = CONVERT;
`ifdef ADC_SEQ_TIMEOUT_EN
          wd_d         = '0;
`endif
        end
      end
      CONVERT: begin
        if (core_conv_finished_in) begin
          data_d       = core_result_in;
          ch_d         = mux_q;
          valid_d      = 1'b1;
          core_rst_n_d = 1'b0;
          state_d      = DELIVER;
        end
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
          err_d        = 1'b1;
          core_rst_n_d = 1'b0;
          advance      = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      DELIVER: begin
        if (valid_q && result_ready_in) begin
          valid_d = 1'b0;
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared channel-advance path for a completed handshake or an abandoned conversion.
    if (advance) begin
      if (!wrap) begin
        mux_d   = next_ch;
        cnt_d   = 8'(SETTLE_CYCLES);
        state_d = SETTLE;
      end else begin
        done_d = 1'b1;
        if (cont_q && !stop_d) begin
          mux_d   = first_ch;
          cnt_d   = 8'(SETTLE_CYCLES);
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      cont_q       <= 1'b0;
      avg_q        <= AVG_1;
      mux_q        <= '0;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      ch_q         <= '0;
      done_q       <= 1'b0;
      stop_q       <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
      err_q        <= 1'b0;
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      cont_q       <= cont_d;
      avg_q        <= avg_d;
      mux_q        <= mux_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= core_rst_n_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      ch_q         <= ch_d;
      done_q       <= done_d;
      stop_q       <= stop_d;
`ifdef ADC_SEQ_TIMEOUT_EN
      err_q        <= err_d;
      wd_q         <= wd_d;
`endif
    end
  end

  assign busy_out             = (state_q != IDLE);
  assign scan_done_strobe_out = done_q;
  assign mux_sel_out          = mux_q;
  assign core_rst_n_out       = core_rst_n_q;
  assign core_avg_control_out = avg_q;
  assign result_valid_out     = valid_q;
  assign result_data_out      = data_q;
  assign result_channel_out   = ch_q;
`ifdef ADC_SEQ_TIMEOUT_EN
  assign error_out            = err_q;
`else
  assign error_out            = 1'b0;
`endif

endmodule

// File: doc/adc_conv_sequencer.md
Name: adc_conv_sequencer

Overview:
- Multi-channel scan controller placed in front of the nonbinary SAR ADC control core.
- Selects the analog input mux channel and waits a settling time. It then releases the core from reset for exactly one conversion and captures the result on the core's finish strobe.
- Delivers {channel, result} to the host over a valid/ready stream.
- Supports single-scan and continuous-scan modes over a channel enable mask.

Parameters:
- MATRIX_BITS, 12, result width of the ADC core.
- NUM_CH, 4, number of analog mux channels (2..16).
- CH_BITS, $clog2(NUM_CH), channel index width (derived).
- SETTLE_CYCLES, 4, mux settling delay in clk cycles (1..255).
- TIMEOUT_CYCLES, 255, conversion watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start_in  in  1  pulse; begins a scan when idle.
- stop_in  in  1  pulse; ends continuous mode after the current scan.
- continuous_in  in  1  sampled at start; 1 = rescan forever.
- channel_mask_in  in  NUM_CH  enabled channels; sampled at start.
- avg_control_in  in  3  averaging code for the core; sampled at start.
- busy_out  out  1  high whenever the block is not IDLE.
- scan_done_strobe_out  out  1  one-cycle pulse after the last enabled channel is delivered.
- mux_sel_out  out  CH_BITS  analog mux select.
- core_rst_n_out  out  1  active-low reset to the ADC core.
- core_avg_control_out  out  3  avg_control to the core.
- core_conv_finished_in  in  1  core finish strobe.
- core_result_in  in  MATRIX_BITS  core result, valid in the strobe cycle.
- result_valid_out  out  1  stream valid.
- result_ready_in  in  1  stream ready.
- result_data_out  out  MATRIX_BITS  conversion result.
- result_channel_out  out  CH_BITS  channel of result_data_out.
- error_out  out  1  sticky; cleared by start_in (only with the optional feature, else tied 0).

Behaviour:
- Reset values: all outputs 0, except core_rst_n_out = 0 (core held in reset). State = IDLE; mux_sel_out = 0.
- State machine has four states: IDLE, SETTLE, CONVERT, DELIVER.
- IDLE:
  - start_in with a nonzero channel_mask_in: latch the mask, continuous_in and avg_control_in. Set mux_sel_out to the lowest enabled channel, load the settle counter with SETTLE_CYCLES, go to SETTLE.
  - start_in with mask == 0 is ignored (stay IDLE, no pulse).
  - start_in while busy is ignored.
- SETTLE:
  - Counter decrements each cycle; core_rst_n_out stays 0.
  - When the counter reaches 1, set core_rst_n_out = 1 on the next edge and go to CONVERT.
- CONVERT:
  - core_rst_n_out = 1; core_avg_control_out holds the latched code throughout, so the core samples it in its sampling cycle.
  - On core_conv_finished_in = 1: capture core_result_in and mux_sel_out into the output register, set result_valid_out, drive core_rst_n_out = 0 on the same edge (exactly one conversion), go to DELIVER.
- DELIVER:
  - Output is held stable while result_valid_out && !result_ready_in.
  - On handshake (valid && ready), clear valid and choose the next enabled channel above the current one.
  - If one exists: set mux_sel_out to it and go to SETTLE.
  - If none exists (wrap): pulse scan_done_strobe_out. Then, if continuous and no stop is pending, select the lowest enabled channel and go to SETTLE; otherwise go to IDLE.
- stop_in at any non-IDLE cycle sets a stop_pending flag; the current scan always completes. stop_pending is cleared on entry to IDLE.
- A single-channel mask in continuous mode converts the same channel repeatedly, with full settling each time.
- A spurious core_conv_finished_in outside CONVERT is ignored.
- Latency, start_in to first result_valid_out: 1 + SETTLE_CYCLES + core conversion time.
- rst mid-scan: immediate return to the reset values. Any pending result is discarded; the core is held in reset.

Optional Feature:
- Macro: ADC_SEQ_TIMEOUT_EN.
- With the macro: an 8-bit-or-wider watchdog counts cycles in CONVERT. If it reaches TIMEOUT_CYCLES without a strobe: set error_out (sticky), drive core_rst_n_out = 0, deliver no result for that channel, and advance exactly as after a handshake.
- Without the macro: no watchdog, and error_out is tied 0.

Decomposition:
- Shared package adc_pkg holds:
  - the state enum (IDLE, SETTLE, CONVERT, DELIVER);
  - avg_control code constants (AVG_1 = 3'b000 through AVG_31 = 3'b100);
  - the default MATRIX_BITS.
- One natural sub-module, adc_next_channel: combinational priority search returning the next set mask bit above the current index, plus a wrap flag.

Test Plan:
- Mask 4'b1011, single scan, SETTLE_CYCLES = 4, ready = 1, core model returning 12'h100 + channel:
  - results are ch0/0x100, ch1/0x101, ch3/0x103;
  - scan_done pulses once, then IDLE;
  - core_rst_n_out is low for ≥4 cycles before each conversion.
- ready held 0 for 20 cycles after the first result: data and channel stay stable, no new SETTLE, core stays in reset; progress resumes 1 cycle after ready = 1.
- Continuous mode with mask 4'b0100, stop_in asserted mid-third conversion: exactly 3 ch2 results and 3 scan_done pulses, then IDLE.
- Edge cases:
  - mask 0 with start: busy_out stays 0;
  - start while busy: ignored, latched mask unchanged;
  - rst asserted in CONVERT: next cycle all outputs are at their reset values.
- ADC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 50, core never strobes on ch1 of mask 4'b0011: error_out = 1, only the ch0 result is delivered, scan_done still pulses.
